// File: rtl/gcd_controller.sv
// Control FSM for the 4-bit subtract-until-equal GCD datapath, with a four-phase go/done handshake.
// Outputs are registered from the next state; a subtraction watchdog ends non-converging runs in err.
module gcd_controller #(
  parameter int MAX_ITER = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             x_neq_y,
  input  logic             x_lt_y,
  output logic             x_sel,
  output logic             y_sel,
  output logic             x_ld,
  output logic             y_ld,
  output logic             d_ld,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMP, S_SUBX, S_SUBY, S_STORE, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             x_sel_q, y_sel_q, x_ld_q, y_ld_q, d_ld_q;
  logic             busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_LOAD;
      S_LOAD:  state_d = S_CMP;
      S_CMP: begin
        if (!x_neq_y)                           state_d = S_STORE;
        else if (iter_q == CNT_W'(MAX_ITER))    state_d = S_ERR;
        else if (x_lt_y)                        state_d = S_SUBY;
        else                                    state_d = S_SUBX;
      end
      S_SUBX:  state_d = S_CMP;
      S_SUBY:  state_d = S_CMP;
      S_STORE: state_d = S_DONE;
      S_DONE:  if (!go) state_d = S_IDLE;
      S_ERR:   if (!go) state_d = S_IDLE;
    endcase
    // The count is a Moore output too, so it moves on entry to the state that owns it.
    if (state_d == S_LOAD)
      iter_d = '0;
    else if (state_d == S_SUBX || state_d == S_SUBY)
      iter_d = iter_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      x_sel_q <= 1'b0;
      y_sel_q <= 1'b0;
      x_ld_q  <= 1'b0;
      y_ld_q  <= 1'b0;
      d_ld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_sel_q <= (state_d == S_SUBX);
      y_sel_q <= (state_d == S_SUBY);
      x_ld_q  <= (state_d == S_LOAD) || (state_d == S_SUBX);
      y_ld_q  <= (state_d == S_LOAD) || (state_d == S_SUBY);
      d_ld_q  <= (state_d == S_STORE);
      busy_q  <= (state_d == S_LOAD) || (state_d == S_CMP) || (state_d == S_SUBX) ||
                 (state_d == S_SUBY) || (state_d == S_STORE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign x_sel      = x_sel_q;
  assign y_sel      = y_sel_q;
  assign x_ld       = x_ld_q;
  assign y_ld       = y_ld_q;
  assign d_ld       = d_ld_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: negedge-loading datapath around the FSM, an algorithmic
// model that predicts the per-cycle control outputs, and directed operand pairs.
module tb_gcd_controller;

  localparam int MAX_ITER = 16;

  // Control word: {x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, err}
  localparam logic [7:0] CTL_IDLE  = 8'b0000_0000;
  localparam logic [7:0] CTL_LOAD  = 8'b0011_0100;
  localparam logic [7:0] CTL_CMP   = 8'b0000_0100;
  localparam logic [7:0] CTL_SUBX  = 8'b1010_0100;
  localparam logic [7:0] CTL_SUBY  = 8'b0101_0100;
  localparam logic [7:0] CTL_STORE = 8'b0000_1100;
  localparam logic [7:0] CTL_DONE  = 8'b0000_0010;
  localparam logic [7:0] CTL_ERR   = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       reset, go;
  logic       x_neq_y, x_lt_y;
  logic       x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, err;
  logic [4:0] iter_count;
  logic [7:0] ctl;

  logic [3:0] ext_x = 4'd0, ext_y = 4'd0;
  logic [3:0] xr = 4'd0, yr = 4'd0, dr = 4'd0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [12:0] exp_q[$];
  logic [12:0] cur;

  gcd_controller #(.MAX_ITER(MAX_ITER), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .go(go), .x_neq_y(x_neq_y), .x_lt_y(x_lt_y),
    .x_sel(x_sel), .y_sel(y_sel), .x_ld(x_ld), .y_ld(y_ld), .d_ld(d_ld),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Datapath: registers load on the falling edge, flags are combinational.
  always @(negedge clk) begin
    if (x_ld) xr <= x_sel ? xr - yr : ext_x;
    if (y_ld) yr <= y_sel ? yr - xr : ext_y;
    if (d_ld) dr <= xr;
  end
  assign x_neq_y = (xr != yr);
  assign x_lt_y  = (xr < yr);
  assign ctl     = {x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, err};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, expv);
    end
  endtask

  // Compare process: one expected entry per cycle while a run is in flight.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("ctl", 32'(ctl), 32'(cur[12:5]));
      chk("iter_count_cyc", 32'(iter_count), 32'(cur[4:0]));
    end
  end

  // Called at a negedge with go low. drop_at = 0 holds go until 3 edges into done/err,
  // otherwise go is first sampled low at edge E(drop_at).
  task automatic run(input int a, input int b, input int drop_at, input int exp_t,
                     input int exp_d, input int exp_k, input bit exp_err);
    int x, y, k, t, dd, l, md;
    bit e;
    logic [7:0] term;
    x = a; y = b; k = 0;
    exp_q.push_back({CTL_LOAD, 5'd0});
    exp_q.push_back({CTL_CMP, 5'd0});
    while (x != y && k < MAX_ITER) begin
      if (x < y) begin y = y - x; exp_q.push_back({CTL_SUBY, 5'(k + 1)}); end
      else       begin x = x - y; exp_q.push_back({CTL_SUBX, 5'(k + 1)}); end
      k++;
      exp_q.push_back({CTL_CMP, 5'(k)});
    end
    e = (x != y);
    if (e) begin
      t = 2 + 2 * k; term = CTL_ERR; md = int'(dr);
    end else begin
      t = 3 + 2 * k; term = CTL_DONE; md = x;
      exp_q.push_back({CTL_STORE, 5'(k)});
    end
    dd = (drop_at != 0) ? drop_at : t + 3;
    l  = (dd > t + 1) ? dd : t + 1;
    for (int i = t; i < l; i++) exp_q.push_back({term, 5'(k)});
    exp_q.push_back({CTL_IDLE, 5'(k)});
    chk("model_latency", 32'(t), 32'(exp_t));
    chk("model_result", 32'(md), 32'(exp_d));
    chk("model_err", 32'(e), 32'(exp_err));

    ext_x = 4'(a); ext_y = 4'(b);
    go = 1'b1;
    for (int i = 0; i <= l; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i + 1 == dd) go = 1'b0;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("d_out", 32'(dr), 32'(exp_d));
    chk("iter_count_final", 32'(iter_count), 32'(exp_k));
  endtask

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 32'(ctl), 32'(CTL_IDLE));
    chk("reset_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run(12, 8, 0, 7, 4, 2, 1'b0);
    run(9, 9, 0, 3, 9, 0, 1'b0);
    run(15, 1, 0, 31, 1, 14, 1'b0);
    run(1, 15, 0, 31, 1, 14, 1'b0);
    run(5, 0, 0, 34, 1, 16, 1'b1);
    run(0, 7, 0, 34, 1, 16, 1'b1);
    run(0, 0, 0, 3, 0, 0, 1'b0);

    // Reset in the middle of a (12,8) run.
    ext_x = 4'd12; ext_y = 4'd8;
    go = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk);
      if (i == 4) begin
        #1;
        chk("midrun_suby", 32'(ctl), 32'(CTL_SUBY));
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_ctl", 32'(ctl), 32'(CTL_IDLE));
    chk("midrun_reset_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    go    = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(ctl), 32'(CTL_IDLE));
    @(negedge clk);
    run(12, 8, 0, 7, 4, 2, 1'b0);

    // go released after E2, then an immediate second request.
    run(6, 4, 3, 7, 2, 2, 1'b0);
    run(10, 15, 0, 7, 5, 2, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM that sequences the 4-bit GCD datapath (subtract-until-equal algorithm). It accepts a four-phase `go`/`done` request, drives the datapath's mux-select and register-load strobes, and watches the `x_neq_y`/`x_lt_y` flags. It signals completion once the result register holds the GCD. A subtraction watchdog flags non-terminating operand pairs (one operand zero, the other non-zero) as errors instead of hanging.

## Interface
- `MAX_ITER`, default 16: subtraction limit; reaching it with `x_neq_y`=1 ends the run in error.
- `CNT_W`, default 5: iteration counter width; must hold `MAX_ITER`.

Ports:
- `clk`  in  1  system clock; FSM updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `go`  in  1  start request (level, four-phase handshake).
- `x_neq_y`  in  1  datapath flag: x register ≠ y register.
- `x_lt_y`  in  1  datapath flag: x register < y register (unsigned).
- `x_sel`  out  1  x mux select: 0 = external operand, 1 = x−y.
- `y_sel`  out  1  y mux select: 0 = external operand, 1 = y−x.
- `x_ld`  out  1  x register load strobe.
- `y_ld`  out  1  y register load strobe.
- `d_ld`  out  1  result register load strobe.
- `busy`  out  1  run in progress.
- `done`  out  1  result valid; handshake acknowledge.
- `err`  out  1  watchdog expired; result register not updated.
- `iter_count`  out  `CNT_W`  subtractions performed in the current or last run.

## Operation
- States: IDLE, LOAD, CMP, SUBX, SUBY, STORE, DONE, ERR. All control outputs are Moore outputs, decoded from state only. Outputs not listed for a state are 0.
- IDLE: if `go`=1, go to LOAD.
- LOAD: `x_ld`=`y_ld`=1, `x_sel`=`y_sel`=0. Clear `iter_count` to 0. Go to CMP.
- CMP: issues no loads. Priority order:
  - `x_neq_y`=0 → STORE.
  - else `iter_count`==`MAX_ITER` → ERR.
  - else `x_lt_y`=1 → SUBY.
  - else → SUBX.
- SUBX: `x_sel`=1, `x_ld`=1, `iter_count`+1. Go to CMP.
- SUBY: `y_sel`=1, `y_ld`=1, `iter_count`+1. Go to CMP.
- STORE: `d_ld`=1. Go to DONE.
- DONE: `done`=1. Stay while `go`=1; go to IDLE when `go`=0.
- ERR: `err`=1. Stay while `go`=1; go to IDLE when `go`=0.
- `busy`=1 in LOAD, CMP, SUBX, SUBY, STORE.
- `go` is ignored from LOAD through STORE; deasserting it early does not abort the run.
- `iter_count` is unsigned and never exceeds `MAX_ITER`. It holds its value through DONE/ERR/IDLE until the next LOAD.
- Operand pair (0,0): equal on the first CMP, result 0, `done` asserted.
- Pair (n,0) or (0,n) with n≠0: never converges, so the run ends in ERR with `iter_count`=`MAX_ITER`.

## Timing
- Datapath registers load on the falling clock edge. A strobe driven in the cycle after rising edge Ek takes effect mid-cycle, so the flags are settled for the CMP decision at Ek+1.
- `go` sampled high at E0:
  - LOAD after E0, CMP after E1.
  - Each subtraction adds 2 cycles, so CMP is entered after E(1+2k) with k = `iter_count`.
  - Converged: STORE after E(2+2k), `done`=1 after E(3+2k). The GCD is already in `d_out`, loaded at the negedge during STORE.
  - Error: `err`=1 after E(2+2·`MAX_ITER`).
- `done`/`err` deassert one cycle after `go` is sampled low. The earliest restart is `go` sampled high at the following edge, from IDLE.
- Reset (any state, including mid-run): next state IDLE. `x_sel`, `y_sel`, `x_ld`, `y_ld`, `d_ld`, `busy`, `done`, `err` = 0; `iter_count`=0. Reset overrides `go`.

## Test plan
- x=12, y=8, `go` held: sequence SUBX, SUBY; `done` after E7; `d_out`=4, `iter_count`=2; `done` drops one cycle after `go`=0.
- x=9, y=9: no subtractions; `done` after E3; `d_out`=9, `iter_count`=0.
- x=15, y=1: 14 SUBX; `done` after E31; `d_out`=1, `iter_count`=14. Also x=1, y=15: 14 SUBY, same result.
- x=5, y=0 and x=0, y=7: `err` after E34, `iter_count`=16, `done` never asserted, `d_out` keeps its prior value. x=0, y=0: `done`, `d_out`=0.
- Reset asserted after E4 of a run with x=12, y=8: FSM in IDLE at the next edge, all outputs 0. A new `go` completes normally.
- `go` dropped after E2, mid-run: run still completes, `done` pulses 1 cycle. Back-to-back runs (6,4) then (10,15): results 2 then 5, no lost requests.
